// File: rtl/mux_2_1.sv
// Two-input WIDTH-bit selector, the leaf cell of the 4:1 tree.
// Ports: s (select), i0/i1 (data), out (s ? i1 : i0).
module mux_2_1 #(
    parameter int WIDTH = 1
) (
    input  logic             s,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    output logic [WIDTH-1:0] out
);

    assign out = s ? i1 : i0;

endmodule

// File: rtl/mux_4_1.sv
// Four-input WIDTH-bit selector as a tree of three 2:1 muxes, with a
// combinational output y and an enabled, async-reset registered copy y_q.
// Ports: clk, rst (async, active-high), i0..i3 (data), s0 (within-pair
// select), s1 (between-pair select), en (y_q load enable), y, y_q.
module mux_4_1 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic [WIDTH-1:0] i2,
    input  logic [WIDTH-1:0] i3,
    input  logic             s0,
    input  logic             s1,
    input  logic             en,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q
);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;

    // s0 resolves each pair first, s1 then picks a pair
    mux_2_1 #(.WIDTH(WIDTH)) m1 (
        .s   (s0),
        .i0  (i0),
        .i1  (i1),
        .out (a)
    );

    mux_2_1 #(.WIDTH(WIDTH)) m2 (
        .s   (s0),
        .i0  (i2),
        .i1  (i3),
        .out (b)
    );

    mux_2_1 #(.WIDTH(WIDTH)) m3 (
        .s   (s1),
        .i0  (a),
        .i1  (b),
        .out (y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_q <= '0;
        end else if (en) begin
            y_q <= y;
        end
    end

endmodule

// File: tb/tb_mux_4_1.sv
// Directed bench for mux_4_1: a WIDTH=1 instance for select sweeps and a
// WIDTH=8 instance for wide data, register, enable and reset behaviour.
module tb_mux_4_1;

    logic       clk;
    logic       rst;
    logic       s0;
    logic       s1;
    logic       en;

    logic       n_i0, n_i1, n_i2, n_i3;
    logic       n_y, n_yq;

    logic [7:0] w_i0, w_i1, w_i2, w_i3;
    logic [7:0] w_y, w_yq;

    int n_cmp;
    int n_bad;

    mux_4_1 #(.WIDTH(1)) u_w1 (
        .clk (clk),
        .rst (rst),
        .i0  (n_i0),
        .i1  (n_i1),
        .i2  (n_i2),
        .i3  (n_i3),
        .s0  (s0),
        .s1  (s1),
        .en  (en),
        .y   (n_y),
        .y_q (n_yq)
    );

    mux_4_1 #(.WIDTH(8)) u_w8 (
        .clk (clk),
        .rst (rst),
        .i0  (w_i0),
        .i1  (w_i1),
        .i2  (w_i2),
        .i3  (w_i3),
        .s0  (s0),
        .s1  (s1),
        .en  (en),
        .y   (w_y),
        .y_q (w_yq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic set_sel(input int k);
        s1 = k[1];
        s0 = k[0];
    endtask

    initial begin
        logic [7:0] exp_w [4];
        logic [7:0] hold;
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        en  = 1'b0;
        s0  = 1'b0;
        s1  = 1'b0;
        n_i0 = 1'b0; n_i1 = 1'b0; n_i2 = 1'b0; n_i3 = 1'b0;
        w_i0 = 8'h11; w_i1 = 8'h22; w_i2 = 8'h44; w_i3 = 8'h88;

        // reset state
        #2;
        check("rst_yq_w1", {7'd0, n_yq}, 8'h00);
        check("rst_yq_w8", w_yq, 8'h00);
        @(posedge clk);
        #1;
        check("rst_hold_w8", w_yq, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // select sweep, WIDTH=1
        n_i0 = 1'b1; n_i1 = 1'b0; n_i2 = 1'b0; n_i3 = 1'b0;
        set_sel(0); #1; check("sweep00", {7'd0, n_y}, 8'h01); #4;
        set_sel(1); #1; check("sweep01", {7'd0, n_y}, 8'h00); #4;
        set_sel(2); #1; check("sweep10", {7'd0, n_y}, 8'h00); #4;
        set_sel(3); #1; check("sweep11", {7'd0, n_y}, 8'h00); #4;

        // one-hot walk
        for (int k = 0; k < 4; k++) begin
            n_i0 = (k == 0);
            n_i1 = (k == 1);
            n_i2 = (k == 2);
            n_i3 = (k == 3);
            for (int s = 0; s < 4; s++) begin
                set_sel(s);
                #1;
                check($sformatf("hot%0d_sel%0d", k, s), {7'd0, n_y},
                      (k == s) ? 8'h01 : 8'h00);
            end
        end

        // wide data
        exp_w[0] = 8'h11; exp_w[1] = 8'h22;
        exp_w[2] = 8'h44; exp_w[3] = 8'h88;
        for (int s = 0; s < 4; s++) begin
            set_sel(s);
            #1;
            check($sformatf("wide_sel%0d", s), w_y, exp_w[s]);
        end

        // register path
        @(negedge clk);
        en = 1'b1;
        set_sel(0);
        @(posedge clk);
        #1;
        check("reg_load00", w_yq, 8'h11);
        @(negedge clk);
        set_sel(3);
        #1;
        check("reg_y_now", w_y, 8'h88);
        check("reg_yq_old", w_yq, 8'h11);
        @(posedge clk);
        #1;
        check("reg_yq_new", w_yq, 8'h88);

        // enable hold
        @(negedge clk);
        set_sel(1);
        @(posedge clk);
        #1;
        check("hold_load", w_yq, 8'h22);
        @(negedge clk);
        en = 1'b0;
        for (int j = 0; j < 3; j++) begin
            hold = 8'h30 + 8'(j);
            w_i0 = hold; w_i1 = hold ^ 8'hFF;
            w_i2 = hold + 8'h40; w_i3 = hold + 8'h80;
            set_sel(j + 1);
            #1;
            case (j)
                0: check("hold_y0", w_y, 8'hCF);
                1: check("hold_y1", w_y, 8'h71);
                default: check("hold_y2", w_y, 8'hB2);
            endcase
            @(posedge clk);
            #1;
            check($sformatf("hold_yq%0d", j), w_yq, 8'h22);
            @(negedge clk);
        end
        w_i0 = 8'h11; w_i1 = 8'h22; w_i2 = 8'h44; w_i3 = 8'h88;

        // async reset
        en = 1'b1;
        set_sel(3);
        @(posedge clk);
        #1;
        check("ar_pre", w_yq, 8'h88);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("ar_clear", w_yq, 8'h00);
        check("ar_y", w_y, 8'h88);
        @(posedge clk);
        #1;
        check("ar_edge", w_yq, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        set_sel(2);
        #1;
        check("ar_rel", w_yq, 8'h00);
        @(posedge clk);
        #1;
        check("ar_first", w_yq, 8'h44);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
